// File: rtl/grn_attractor_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// grn_attractor_ctrl : sweeps initial states, runs Floyd detection, reports period
// Rev 1.0
// ---------------------------------------------------------------------------
module grn_attractor_ctrl #(
  parameter int N_NODES   = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_STEPS = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_NODES-1:0] init_first,
  input  logic [N_NODES-1:0] init_last,
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec,
  output logic               reset_nos,
  output logic               start_s0,
  output logic               start_s1,
  output logic [N_NODES-1:0] init_state,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [N_NODES-1:0] res_init,
  output logic [CNT_W-1:0]   res_steps,
  output logic [CNT_W-1:0]   res_period,
  output logic               res_timeout,
  output logic               busy,
  output logic               done
);

  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_STEPS);
  localparam logic [CNT_W-1:0] MIN_STEPS = CNT_W'(2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SEARCH = 3'd2,
    PERIOD = 3'd3,
    REPORT = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [N_NODES-1:0] cur;
  logic [N_NODES-1:0] last;
  logic [CNT_W-1:0]   step_cnt;
  logic [CNT_W-1:0]   period_cnt;

  logic vec_eq;
  logic search_match;
  logic search_tmo;
  logic period_first;
  logic period_match;
  logic period_tmo;
  logic at_last;

  // Before two hare steps the copies trivially agree, so matches are masked.
  assign vec_eq       = (s0_vec == s1_vec);
  assign search_match = vec_eq && (step_cnt >= MIN_STEPS);
  assign search_tmo   = !search_match && (step_cnt == MAX_CNT);
  assign period_first = (period_cnt == '0);
  assign period_match = !period_first && vec_eq;
  assign period_tmo   = !period_first && !vec_eq && (period_cnt == MAX_CNT);
  assign at_last      = (cur == last);

  assign res_valid = (state == REPORT);
  assign done      = (state == DONE);
  assign busy      = (state != IDLE) && (state != DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    reset_nos  = 1'b0;
    start_s0   = 1'b0;
    start_s1   = 1'b0;
    init_state = '0;
    case (state)
      IDLE, DONE: if (start) state_nxt = LOAD;
      LOAD: begin
        reset_nos  = 1'b1;
        init_state = cur;
        state_nxt  = SEARCH;
      end
      SEARCH: begin
        if (search_match)    state_nxt = PERIOD;
        else if (search_tmo) state_nxt = REPORT;
        else begin
          start_s0 = 1'b1;
          start_s1 = 1'b1;
        end
      end
      // Tortoise stays parked on the cycle; the hare walks it once around.
      PERIOD: begin
        if (period_match || period_tmo) state_nxt = REPORT;
        else                            start_s1  = 1'b1;
      end
      REPORT: if (res_ready) state_nxt = at_last ? DONE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur         <= '0;
      last        <= '0;
      step_cnt    <= '0;
      period_cnt  <= '0;
      res_init    <= '0;
      res_steps   <= '0;
      res_period  <= '0;
      res_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cur  <= init_first;
            last <= init_last;
          end
        end
        LOAD: begin
          step_cnt    <= '0;
          period_cnt  <= '0;
          res_init    <= cur;
          res_steps   <= '0;
          res_period  <= '0;
          res_timeout <= 1'b0;
        end
        SEARCH: begin
          if (search_match) begin
            res_steps <= step_cnt;
          end else if (search_tmo) begin
            res_steps   <= step_cnt;
            res_timeout <= 1'b1;
            res_period  <= '0;
          end else begin
            step_cnt <= step_cnt + CNT_W'(1);
          end
        end
        PERIOD: begin
          if (period_first) begin
            period_cnt <= CNT_W'(1);
          end else if (period_match) begin
            res_period <= period_cnt;
          end else if (period_tmo) begin
            res_timeout <= 1'b1;
            res_period  <= '0;
          end else begin
            period_cnt <= period_cnt + CNT_W'(1);
          end
        end
        // DONE is taken at init_last, so cur never wraps past the top of range.
        REPORT: if (res_ready && !at_last) cur <= cur + N_NODES'(1);
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
